// File: rtl/pfcop_host_ctrl.sv
// pfcop_host_ctrl: takes one (op, a, b, p) request and runs it on PFCOP over the 16-bit load, op-enable and readout ports.
// Latency: 48 load cycles (32 on a p-cache hit), 1 GO cycle, ready-dependent WAIT, 16+RD_LAT READ cycles, then a 1-cycle done.
// Backpressure: busy blocks new requests, and a start seen while busy is dropped; WAIT gives up after TIMEOUT_CYC cycles with err=1.
// Ports: start/op/op_a/op_b/op_p in; busy/done/err/result out; cop_* connect to PFCOP.
// Optional feature: define PFCOP_HOST_PCACHE_EN to skip the p load when op_p matches the last p that was fully loaded.
module pfcop_host_ctrl #(
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [255:0] op_a,
  input  logic [255:0] op_b,
  input  logic [255:0] op_p,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [255:0] result,
  output logic         cop_load_en,
  output logic [3:0]   cop_load_addr,
  output logic [15:0]  cop_datain,
  output logic         cop_madd_en,
  output logic         cop_msub_en,
  output logic         cop_mmul_en,
  output logic         cop_minv_mdiv_en,
  output logic         cop_minv_mdiv,
  output logic         cop_out_en,
  output logic [1:0]   cop_out_addr,
  input  logic [15:0]  cop_dataout,
  input  logic         cop_madd_msub_rdy,
  input  logic         cop_mmul_rdy,
  input  logic         cop_minv_mdiv_rdy
);
  localparam int RD_CYC = 16 + RD_LAT;
  localparam int RW     = $clog2(RD_CYC + 1);
  localparam int TW     = $clog2(TIMEOUT_CYC + 1);

  localparam logic [2:0] OP_MADD = 3'd0;
  localparam logic [2:0] OP_MSUB = 3'd1;
  localparam logic [2:0] OP_MMUL = 3'd2;
  localparam logic [2:0] OP_MINV = 3'd3;
  localparam logic [2:0] OP_MDIV = 3'd4;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GO, S_WAIT, S_READ, S_DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]    op_q;
  logic [255:0]  a_q, b_q, p_q;
  logic [5:0]    ld_cnt;
  logic [RW-1:0] rd_cnt;
  logic [TW-1:0] to_cnt;
  logic          rdy_q, err_q;
  logic          op_legal, rdy_sel, rdy_rise, load_last, timeout, rd_last, rd_capture;
  logic [3:0]    ld_word, rd_word;

  assign op_legal   = (op <= OP_MDIV);
  assign ld_word    = ld_cnt[3:0];
  assign rd_word    = 4'(rd_cnt - RW'(RD_LAT));
  assign rd_capture = (rd_cnt >= RW'(RD_LAT));
  assign rd_last    = (rd_cnt == RW'(RD_CYC - 1));
  // to_cnt is 1 in the first WAIT cycle, so done lands exactly TIMEOUT_CYC cycles after GO.
  assign timeout    = (to_cnt == TW'(TIMEOUT_CYC - 1));
  // Rising edge only: a ready still high from the previous op must not complete this one.
  assign rdy_rise   = rdy_sel && !rdy_q;
  assign cop_out_addr = 2'b00;

`ifdef PFCOP_HOST_PCACHE_EN
  logic [255:0] p_cache;
  logic         p_cache_vld;
  logic         skip_p;
  assign load_last = skip_p ? (ld_cnt == 6'd31) : (ld_cnt == 6'd47);
`else
  assign load_last = (ld_cnt == 6'd47);
`endif

  always_comb begin
    case (op_q)
      OP_MADD, OP_MSUB: rdy_sel = cop_madd_msub_rdy;
      OP_MMUL:          rdy_sel = cop_mmul_rdy;
      default:          rdy_sel = cop_minv_mdiv_rdy;
    endcase
  end

  always_comb begin
    state_nxt        = state;
    busy             = 1'b0;
    done             = 1'b0;
    err              = 1'b0;
    cop_load_en      = 1'b0;
    cop_load_addr    = 4'd0;
    cop_datain       = 16'd0;
    cop_madd_en      = 1'b0;
    cop_msub_en      = 1'b0;
    cop_mmul_en      = 1'b0;
    cop_minv_mdiv_en = 1'b0;
    cop_minv_mdiv    = 1'b0;
    cop_out_en       = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (state == S_DONE) begin
          done = 1'b1;
          err  = err_q;
        end
        // An illegal op takes the DONE state directly: err pulse, no PFCOP traffic.
        if (start) state_nxt = op_legal ? S_LOAD : S_DONE;
        else       state_nxt = S_IDLE;
      end
      S_LOAD: begin
        busy          = 1'b1;
        cop_load_en   = 1'b1;
        cop_load_addr = {2'b00, ld_cnt[5:4]};
        case (ld_cnt[5:4])
          2'd0:    cop_datain = a_q[{ld_word, 4'b0000} +: 16];
          2'd1:    cop_datain = b_q[{ld_word, 4'b0000} +: 16];
          default: cop_datain = p_q[{ld_word, 4'b0000} +: 16];
        endcase
        if (load_last) state_nxt = S_GO;
      end
      S_GO: begin
        busy             = 1'b1;
        cop_madd_en      = (op_q == OP_MADD);
        cop_msub_en      = (op_q == OP_MSUB);
        cop_mmul_en      = (op_q == OP_MMUL);
        cop_minv_mdiv_en = (op_q == OP_MINV) || (op_q == OP_MDIV);
        cop_minv_mdiv    = (op_q == OP_MDIV);
        state_nxt        = S_WAIT;
      end
      S_WAIT: begin
        busy          = 1'b1;
        cop_minv_mdiv = (op_q == OP_MDIV);
        if (rdy_rise)     state_nxt = S_READ;
        else if (timeout) state_nxt = S_DONE;
      end
      S_READ: begin
        busy       = 1'b1;
        cop_out_en = 1'b1;
        if (rd_last) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= 3'd0;
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
      ld_cnt <= '0;
      rd_cnt <= '0;
      to_cnt <= '0;
      rdy_q  <= 1'b0;
      err_q  <= 1'b0;
      result <= '0;
`ifdef PFCOP_HOST_PCACHE_EN
      p_cache     <= '0;
      p_cache_vld <= 1'b0;
      skip_p      <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      rdy_q <= rdy_sel;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            err_q <= ~op_legal;
            if (op_legal) begin
              op_q   <= op;
              a_q    <= op_a;
              b_q    <= op_b;
              p_q    <= op_p;
              ld_cnt <= '0;
              result <= '0;
`ifdef PFCOP_HOST_PCACHE_EN
              skip_p <= p_cache_vld && (op_p == p_cache);
`endif
            end
          end
        end
        S_LOAD: begin
          ld_cnt <= ld_cnt + 6'd1;
`ifdef PFCOP_HOST_PCACHE_EN
          // The cache becomes valid only once the last p word has actually gone out.
          if (ld_cnt == 6'd47) begin
            p_cache     <= p_q;
            p_cache_vld <= 1'b1;
          end
`endif
        end
        S_GO: to_cnt <= TW'(1);
        S_WAIT: begin
          to_cnt <= to_cnt + TW'(1);
          rd_cnt <= '0;
          if (!rdy_rise && timeout) begin
            err_q  <= 1'b1;
            result <= '0;
`ifdef PFCOP_HOST_PCACHE_EN
            // After a timeout PFCOP's p register can no longer be trusted.
            p_cache_vld <= 1'b0;
`endif
          end
        end
        S_READ: begin
          rd_cnt <= rd_cnt + RW'(1);
          if (rd_capture) result[{rd_word, 4'b0000} +: 16] <= cop_dataout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pfcop_host_ctrl.sv
// tb_pfcop_host_ctrl: directed bench for pfcop_host_ctrl with a small behavioural PFCOP model.
// The model rebuilds operands from the load port, computes madd/msub, and raises ready 6 cycles after an enable.
// Each test task drives one scenario and compares against hand-derived cycle numbers and values.
module tb_pfcop_host_ctrl;
  localparam int TO = 4096;
  localparam logic [255:0] A  = 256'h63E4C6D3_1A2B3C4D_5E6F7081_92A3B4C5_D6E7F809_1A2B3C4D_5E6F7081_27C5249A;
  localparam logic [255:0] B  = 256'h787968B4_0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0_0F1E2D3C_4B5A6978_3937E498;
  localparam logic [255:0] P  = 256'h8542D69E_11223344_55667788_99AABBCC_DDEEFF00_11223344_55667788_08F1DFC3;
  localparam logic [255:0] P2 = 256'h9000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0061;
  localparam logic [255:0] P3 = 256'h9000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0067;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [2:0] op = 3'd0;
  logic [255:0] op_a = '0, op_b = '0, op_p = '0;
  logic busy, done, err;
  logic [255:0] result;
  logic cop_load_en, cop_madd_en, cop_msub_en, cop_mmul_en, cop_minv_mdiv_en, cop_minv_mdiv, cop_out_en;
  logic [3:0] cop_load_addr;
  logic [15:0] cop_datain;
  logic [15:0] cop_dataout = 16'd0;
  logic [1:0] cop_out_addr;
  logic cop_madd_msub_rdy, cop_mmul_rdy, cop_minv_mdiv_rdy;

  pfcop_host_ctrl #(.RD_LAT(1), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .op_a(op_a), .op_b(op_b), .op_p(op_p),
    .busy(busy), .done(done), .err(err), .result(result),
    .cop_load_en(cop_load_en), .cop_load_addr(cop_load_addr), .cop_datain(cop_datain),
    .cop_madd_en(cop_madd_en), .cop_msub_en(cop_msub_en), .cop_mmul_en(cop_mmul_en),
    .cop_minv_mdiv_en(cop_minv_mdiv_en), .cop_minv_mdiv(cop_minv_mdiv),
    .cop_out_en(cop_out_en), .cop_out_addr(cop_out_addr), .cop_dataout(cop_dataout),
    .cop_madd_msub_rdy(cop_madd_msub_rdy), .cop_mmul_rdy(cop_mmul_rdy), .cop_minv_mdiv_rdy(cop_minv_mdiv_rdy)
  );

  always #5 clk = ~clk;

  // ---------------- PFCOP model ----------------
  int rdy_mode = 0;  // 0 = model timing, 1 = all ready low, 2 = all ready high
  logic [255:0] ma = '0, mb = '0, mp = '0, mres = '0;
  logic m_ld_prev = 1'b0;
  logic [3:0] m_addr_prev = 4'd0, m_widx_prev = 4'd0, m_wi, m_ridx = 4'd0;
  logic [2:0] m_rdy = 3'b000;
  int m_cnt [3] = '{0, 0, 0};
  logic [2:0] en_vec;
  assign en_vec = {cop_minv_mdiv_en, cop_mmul_en, cop_madd_en | cop_msub_en};
  assign m_wi = (m_ld_prev && cop_load_addr == m_addr_prev) ? m_widx_prev + 4'd1 : 4'd0;
  assign cop_madd_msub_rdy = (rdy_mode == 1) ? 1'b0 : (rdy_mode == 2) ? 1'b1 : m_rdy[0];
  assign cop_mmul_rdy      = (rdy_mode == 1) ? 1'b0 : (rdy_mode == 2) ? 1'b1 : m_rdy[1];
  assign cop_minv_mdiv_rdy = (rdy_mode == 1) ? 1'b0 : (rdy_mode == 2) ? 1'b1 : m_rdy[2];

  function automatic logic [255:0] f_madd(input logic [255:0] x, y, m);
    logic [256:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return s[255:0];
  endfunction

  function automatic logic [255:0] f_msub(input logic [255:0] x, y, m);
    return (x >= y) ? x - y : x - y + m;
  endfunction

  always @(posedge clk) begin
    m_ld_prev   <= cop_load_en;
    m_addr_prev <= cop_load_addr;
    m_widx_prev <= m_wi;
    if (cop_load_en) begin
      case (cop_load_addr)
        4'd0: ma[{m_wi, 4'b0000} +: 16] <= cop_datain;
        4'd1: mb[{m_wi, 4'b0000} +: 16] <= cop_datain;
        4'd2: mp[{m_wi, 4'b0000} +: 16] <= cop_datain;
        default: ;
      endcase
    end
    if (cop_madd_en) mres <= f_madd(ma, mb, mp);
    if (cop_msub_en) mres <= f_msub(ma, mb, mp);
    if (cop_mmul_en || cop_minv_mdiv_en) mres <= ma ^ mb ^ mp;
    for (int i = 0; i < 3; i++) begin
      if (en_vec[i]) begin
        m_rdy[i] <= 1'b0;
        m_cnt[i] <= 5;
      end else if (m_cnt[i] != 0) begin
        m_cnt[i] <= m_cnt[i] - 1;
        if (m_cnt[i] == 1) m_rdy[i] <= 1'b1;
      end
    end
    if (cop_out_en) begin
      cop_dataout <= mres[{m_ridx, 4'b0000} +: 16];
      m_ridx <= m_ridx + 4'd1;
    end else begin
      m_ridx <= 4'd0;
    end
  end

  // ---------------- monitor ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0]  log_addr [0:1023];
  logic [15:0] log_dat  [0:1023];
  int          log_cyc  [0:1023];
  int n_log = 0, n_madd = 0, n_msub = 0, n_mmul = 0, n_mimd = 0, go_cyc = 0;
  int n_done = 0, done_cyc = 0, n_busy = 0, n_outen = 0, n_addr2 = 0;
  logic done_err = 1'b0;

  always @(negedge clk) begin
    if (cop_load_en) begin
      log_addr[n_log & 1023] <= cop_load_addr;
      log_dat[n_log & 1023]  <= cop_datain;
      log_cyc[n_log & 1023]  <= cyc;
      n_log <= n_log + 1;
      if (cop_load_addr == 4'd2) n_addr2 <= n_addr2 + 1;
    end
    if (cop_madd_en)      begin n_madd <= n_madd + 1; go_cyc <= cyc; end
    if (cop_msub_en)      begin n_msub <= n_msub + 1; go_cyc <= cyc; end
    if (cop_mmul_en)      begin n_mmul <= n_mmul + 1; go_cyc <= cyc; end
    if (cop_minv_mdiv_en) begin n_mimd <= n_mimd + 1; go_cyc <= cyc; end
    if (done) begin n_done <= n_done + 1; done_cyc <= cyc; done_err <= err; end
    if (busy) n_busy <= n_busy + 1;
    if (cop_out_en) n_outen <= n_outen + 1;
  end

  // ---------------- bench bookkeeping ----------------
  int n_vec = 0, n_bad = 0;
  bit cache_vld = 1'b0;
  logic [255:0] cache_p = '0;

  function automatic int exp_words(input logic [255:0] p);
`ifdef PFCOP_HOST_PCACHE_EN
    return (cache_vld && p == cache_p) ? 32 : 48;
`else
    return (p == p) ? 48 : 48;
`endif
  endfunction

  task automatic launch(input logic [2:0] o, input logic [255:0] a, b, p, output int c0);
    @(negedge clk); #1;
    start = 1'b1; op = o; op_a = a; op_b = b; op_p = p; c0 = cyc;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (n_done > base) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_vec++; if ({busy, done, err} !== 3'b000) begin n_bad++; $display("FAIL reset_status: got %b expected 000", {busy, done, err}); end
    n_vec++; if (result !== '0) begin n_bad++; $display("FAIL reset_result: got %h expected 0", result); end
    n_vec++; if ({cop_load_en, cop_load_addr, cop_datain} !== 21'd0) begin n_bad++; $display("FAIL reset_load: got %h expected 0", {cop_load_en, cop_load_addr, cop_datain}); end
    n_vec++; if ({cop_madd_en, cop_msub_en, cop_mmul_en, cop_minv_mdiv_en, cop_minv_mdiv, cop_out_en, cop_out_addr} !== 8'd0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b expected 0", {cop_madd_en, cop_msub_en, cop_mmul_en, cop_minv_mdiv_en, cop_minv_mdiv, cop_out_en, cop_out_addr});
    end
    rst = 1'b0;
  endtask

  task automatic test_madd();
    int c0, nw, b_log, b_madd, b_oth, b_done, b_busy, b_out;
    bit ok;
    nw = exp_words(P);
    b_log = n_log; b_madd = n_madd; b_oth = n_msub + n_mmul + n_mimd; b_done = n_done; b_busy = n_busy; b_out = n_outen;
    launch(3'd0, A, B, P, c0);
    wait_done(b_done, 300, ok);
    n_vec++; if (!ok) begin n_bad++; $display("FAIL madd_done_seen: got no done expected done within 300 cycles"); end
    n_vec++; if (n_log - b_log !== nw) begin n_bad++; $display("FAIL madd_load_count: got %0d expected %0d", n_log - b_log, nw); end
    for (int i = 0; i < nw; i++) begin
      int k;
      logic [255:0] src;
      logic [3:0] ea;
      logic [15:0] ed;
      k = (b_log + i) & 1023;
      ea = 4'(i / 16);
      src = (i < 16) ? A : (i < 32) ? B : P;
      ed = src[(i % 16) * 16 +: 16];
      n_vec++;
      if (log_addr[k] !== ea || log_dat[k] !== ed || log_cyc[k] !== c0 + 1 + i) begin
        n_bad++; $display("FAIL madd_load_word%0d: got addr %0d data %h cycle %0d expected addr %0d data %h cycle %0d",
                          i, log_addr[k], log_dat[k], log_cyc[k] - c0, ea, ed, 1 + i);
      end
    end
    n_vec++; if (n_madd - b_madd !== 1 || go_cyc - c0 !== nw + 1) begin n_bad++; $display("FAIL madd_go_pulse: got %0d pulses at cycle %0d expected 1 at %0d", n_madd - b_madd, go_cyc - c0, nw + 1); end
    n_vec++; if (n_msub + n_mmul + n_mimd - b_oth !== 0) begin n_bad++; $display("FAIL madd_other_en: got %0d pulses expected 0", n_msub + n_mmul + n_mimd - b_oth); end
    n_vec++; if (done_cyc - c0 !== nw + 25 || done_err !== 1'b0) begin n_bad++; $display("FAIL madd_done: got cycle %0d err %b expected cycle %0d err 0", done_cyc - c0, done_err, nw + 25); end
    n_vec++; if (result !== A + B - P) begin n_bad++; $display("FAIL madd_result: got %h expected %h", result, A + B - P); end
    n_vec++; if (n_busy - b_busy !== nw + 24) begin n_bad++; $display("FAIL madd_busy_len: got %0d expected %0d", n_busy - b_busy, nw + 24); end
    n_vec++; if (n_outen - b_out !== 17) begin n_bad++; $display("FAIL madd_out_en_len: got %0d expected 17", n_outen - b_out); end
    cache_vld = 1'b1; cache_p = P;
  endtask

  task automatic test_msub();
    int c0, nw, b_msub, b_oth, b_done, b_log;
    bit ok;
    nw = exp_words(P);
    b_msub = n_msub; b_oth = n_madd + n_mmul + n_mimd; b_done = n_done; b_log = n_log;
    launch(3'd1, A, B, P, c0);
    wait_done(b_done, 300, ok);
    n_vec++; if (!ok) begin n_bad++; $display("FAIL msub_done_seen: got no done expected done within 300 cycles"); end
    n_vec++; if (n_log - b_log !== nw) begin n_bad++; $display("FAIL msub_load_count: got %0d expected %0d", n_log - b_log, nw); end
    n_vec++; if (n_msub - b_msub !== 1 || go_cyc - c0 !== nw + 1) begin n_bad++; $display("FAIL msub_go_pulse: got %0d pulses at cycle %0d expected 1 at %0d", n_msub - b_msub, go_cyc - c0, nw + 1); end
    n_vec++; if (n_madd + n_mmul + n_mimd - b_oth !== 0) begin n_bad++; $display("FAIL msub_other_en: got %0d expected 0", n_madd + n_mmul + n_mimd - b_oth); end
    n_vec++; if (done_cyc - c0 !== nw + 25 || done_err !== 1'b0) begin n_bad++; $display("FAIL msub_done: got cycle %0d err %b expected cycle %0d err 0", done_cyc - c0, done_err, nw + 25); end
    n_vec++; if (result !== A - B + P) begin n_bad++; $display("FAIL msub_result: got %h expected %h", result, A - B + P); end
    op_a = ~A; op_p = ~P;
    repeat (10) @(negedge clk);
    #1;
    n_vec++; if (result !== A - B + P) begin n_bad++; $display("FAIL msub_result_hold: got %h expected %h", result, A - B + P); end
    cache_vld = 1'b1; cache_p = P;
  endtask

  task automatic test_illegal();
    int c0, b_done, b_log, b_busy;
    b_done = n_done; b_log = n_log; b_busy = n_busy;
    launch(3'd6, A, B, P, c0);
    repeat (4) @(negedge clk);
    #1;
    n_vec++; if (n_done - b_done !== 1 || done_cyc - c0 !== 1 || done_err !== 1'b1) begin
      n_bad++; $display("FAIL illegal_done: got %0d pulses cycle %0d err %b expected 1 pulse cycle 1 err 1", n_done - b_done, done_cyc - c0, done_err);
    end
    n_vec++; if (n_log - b_log !== 0 || n_busy - b_busy !== 0) begin n_bad++; $display("FAIL illegal_traffic: got loads %0d busy %0d expected 0 0", n_log - b_log, n_busy - b_busy); end
  endtask

  task automatic test_busy_start();
    int c0, nw, b_done, b_log, b_madd, b_msub;
    bit ok;
    nw = exp_words(P);
    b_done = n_done; b_log = n_log; b_madd = n_madd; b_msub = n_msub;
    launch(3'd0, A, B, P, c0);
    for (int i = 0; i < 20 && n_log - b_log < 10; i++) begin @(negedge clk); #1; end
    start = 1'b1; op = 3'd1; op_a = B; op_b = A;
    @(negedge clk); #1;
    start = 1'b0;
    wait_done(b_done, 300, ok);
    repeat (5) @(negedge clk);
    #1;
    n_vec++; if (!ok || n_done - b_done !== 1) begin n_bad++; $display("FAIL busy_start_done_count: got %0d expected 1", n_done - b_done); end
    n_vec++; if (n_madd - b_madd !== 1 || n_msub - b_msub !== 0) begin n_bad++; $display("FAIL busy_start_enables: got madd %0d msub %0d expected 1 0", n_madd - b_madd, n_msub - b_msub); end
    n_vec++; if (n_log - b_log !== nw) begin n_bad++; $display("FAIL busy_start_loads: got %0d expected %0d", n_log - b_log, nw); end
    n_vec++; if (result !== A + B - P || done_err !== 1'b0) begin n_bad++; $display("FAIL busy_start_result: got %h err %b expected %h err 0", result, done_err, A + B - P); end
    cache_vld = 1'b1; cache_p = P;
  endtask

  task automatic test_timeout();
    for (int m = 1; m <= 2; m++) begin
      int c0, nw, b_done, b_out;
      bit ok;
      rdy_mode = m;
      nw = exp_words(P);
      b_done = n_done; b_out = n_outen;
      launch(3'd2, A, B, P, c0);
      wait_done(b_done, TO + 200, ok);
      n_vec++; if (!ok || done_cyc - c0 !== nw + 1 + TO) begin n_bad++; $display("FAIL timeout_cycle_mode%0d: got %0d expected %0d", m, done_cyc - c0, nw + 1 + TO); end
      n_vec++; if (done_err !== 1'b1 || result !== '0) begin n_bad++; $display("FAIL timeout_err_mode%0d: got err %b result %h expected err 1 result 0", m, done_err, result); end
      n_vec++; if (n_outen - b_out !== 0) begin n_bad++; $display("FAIL timeout_no_read_mode%0d: got %0d expected 0", m, n_outen - b_out); end
      cache_vld = 1'b0;
    end
    rdy_mode = 0;
  endtask

  task automatic test_rst_mid();
    int c0, b_done, b_log;
    bit ok;
    b_done = n_done; b_log = n_log;
    launch(3'd0, A, B, P, c0);
    for (int i = 0; i < 40 && n_log - b_log < 21; i++) begin @(negedge clk); #1; end
    rst = 1'b1;
    @(negedge clk); #1;
    n_vec++; if ({cop_load_en, cop_load_addr, cop_datain, cop_madd_en, cop_msub_en, cop_mmul_en, cop_minv_mdiv_en, cop_minv_mdiv, cop_out_en, cop_out_addr} !== '0) begin
      n_bad++; $display("FAIL rst_mid_cop_outputs: got %h expected 0", {cop_load_en, cop_load_addr, cop_datain, cop_madd_en, cop_msub_en, cop_mmul_en, cop_minv_mdiv_en, cop_minv_mdiv, cop_out_en, cop_out_addr});
    end
    n_vec++; if (busy !== 1'b0 || n_log - b_log !== 21) begin n_bad++; $display("FAIL rst_mid_stop: got busy %b loads %0d expected busy 0 loads 21", busy, n_log - b_log); end
    rst = 1'b0;
    cache_vld = 1'b0;
    repeat (100) @(negedge clk);
    #1;
    n_vec++; if (n_done - b_done !== 0) begin n_bad++; $display("FAIL rst_mid_no_done: got %0d expected 0", n_done - b_done); end
    b_log = n_log;
    launch(3'd0, A, B, P, c0);
    wait_done(b_done, 300, ok);
    n_vec++; if (!ok || n_log - b_log !== 48 || done_cyc - c0 !== 73) begin n_bad++; $display("FAIL rst_mid_rerun: got loads %0d done cycle %0d expected 48 73", n_log - b_log, done_cyc - c0); end
    n_vec++; if (result !== A + B - P) begin n_bad++; $display("FAIL rst_mid_result: got %h expected %h", result, A + B - P); end
    cache_vld = 1'b1; cache_p = P;
  endtask

  task automatic test_pcache();
    logic [255:0] plist [3];
    plist = '{P2, P2, P3};
    for (int r = 0; r < 3; r++) begin
      int c0, nw, b_done, b_log, b_a2, b_mmul;
      bit ok;
      nw = exp_words(plist[r]);
      b_done = n_done; b_log = n_log; b_a2 = n_addr2; b_mmul = n_mmul;
      launch(3'd2, A, B, plist[r], c0);
      wait_done(b_done, 300, ok);
      n_vec++; if (!ok || n_log - b_log !== nw || n_addr2 - b_a2 !== nw - 32) begin
        n_bad++; $display("FAIL pcache_loads_run%0d: got loads %0d addr2 %0d expected %0d %0d", r, n_log - b_log, n_addr2 - b_a2, nw, nw - 32);
      end
      n_vec++; if (n_mmul - b_mmul !== 1 || go_cyc - c0 !== nw + 1) begin n_bad++; $display("FAIL pcache_go_run%0d: got %0d pulses cycle %0d expected 1 at %0d", r, n_mmul - b_mmul, go_cyc - c0, nw + 1); end
      n_vec++; if (result !== (A ^ B ^ plist[r]) || done_err !== 1'b0) begin n_bad++; $display("FAIL pcache_result_run%0d: got %h err %b expected %h err 0", r, result, done_err, A ^ B ^ plist[r]); end
      cache_vld = 1'b1; cache_p = plist[r];
    end
  endtask

  initial begin
    test_reset();
    test_madd();
    test_msub();
    test_illegal();
    test_busy_start();
    test_timeout();
    test_rst_mid();
    test_pcache();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
